// File: rtl/eeg_pea_out_arb.sv
// Output arbiter between the PE array and the single output-RAM write port.
// Grants one PE beat per cycle in round-robin order. Each granted beat goes
// into a registered ORAM write slot whose address is {pe index, local add}.
// The arbiter records which PEs have delivered their last beat. DONE pulses
// once the final beat of the run has left the slot.
module eeg_pea_out_arb #(
  parameter  int PE_NUM      = 16,
  parameter  int DATA_OUT_DW = 8,
  parameter  int OMUX_ADD_AW = 8,
  localparam int PE_IDX_AW   = $clog2(PE_NUM),
  localparam int ORAM_ADD_AW = PE_IDX_AW + OMUX_ADD_AW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          CFG_START,
  output logic                          IS_IDLE,
  output logic                          DONE,
  input  logic [PE_NUM-1:0]             PE_OUT_VLD,
  input  logic [PE_NUM-1:0]             PE_OUT_LST,
  output logic [PE_NUM-1:0]             PE_OUT_RDY,
  input  logic [PE_NUM*DATA_OUT_DW-1:0] PE_OUT_DAT,
  input  logic [PE_NUM*OMUX_ADD_AW-1:0] PE_OUT_ADD,
  output logic                          ORAM_VLD,
  input  logic                          ORAM_RDY,
  output logic                          ORAM_LST,
  output logic [ORAM_ADD_AW-1:0]        ORAM_ADD,
  output logic [DATA_OUT_DW-1:0]        ORAM_DAT
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [PE_IDX_AW-1:0]   ptr, ptr_after, win_idx, cand_idx;
  logic [PE_NUM-1:0]      lst_seen, lst_seen_upd, req, win_onehot;
  logic [DATA_OUT_DW-1:0] win_dat;
  logic [OMUX_ADD_AW-1:0] win_add;
  logic                   win_found, win_lst, slot_free, grant, final_beat, done_nxt;
  int                     cand;

  assign slot_free = ~ORAM_VLD | ORAM_RDY;
  assign req       = PE_OUT_VLD & ~lst_seen;
  assign IS_IDLE   = (state == IDLE);

  // Round-robin search: first requesting PE at or after ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      cand = int'(ptr) + i;
      if (cand >= PE_NUM) cand = cand - PE_NUM;
      cand_idx = PE_IDX_AW'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Select the winner's data, local address and last flag
  always_comb begin
    win_dat = '0;
    win_add = '0;
    win_lst = 1'b0;
    for (int j = 0; j < PE_NUM; j++) begin
      if (PE_IDX_AW'(j) == win_idx) begin
        win_dat = PE_OUT_DAT[j*DATA_OUT_DW +: DATA_OUT_DW];
        win_add = PE_OUT_ADD[j*OMUX_ADD_AW +: OMUX_ADD_AW];
        win_lst = PE_OUT_LST[j];
      end
    end
  end

  // Grant decision, one-hot ready and last-beat bookkeeping
  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
    grant        = (state == RUN) && slot_free && win_found;
    PE_OUT_RDY   = grant ? win_onehot : '0;
    lst_seen_upd = lst_seen | ((grant && win_lst) ? win_onehot : '0);
    final_beat   = win_lst && (&(lst_seen | win_onehot));
    ptr_after    = (win_idx == PE_IDX_AW'(PE_NUM - 1)) ? '0 : win_idx + PE_IDX_AW'(1);
  end

  // Next-state logic; DONE waits until the slot has released its last beat
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:    if (CFG_START) state_nxt = RUN;
      RUN:     if (&lst_seen_upd) state_nxt = DRAIN;
      DRAIN: begin
        if (slot_free) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, rr pointer (kept across runs), last-seen mask, DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      lst_seen <= '0;
      DONE     <= 1'b0;
    end else begin
      state <= state_nxt;
      DONE  <= done_nxt;
      if (grant) ptr <= ptr_after;
      if (state == IDLE && CFG_START) lst_seen <= '0;
      else if (state == RUN)          lst_seen <= lst_seen_upd;
    end
  end

  // ORAM write slot: loads on grant, empties when free and idle, else holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ORAM_VLD <= 1'b0;
      ORAM_LST <= 1'b0;
      ORAM_ADD <= '0;
      ORAM_DAT <= '0;
    end else if (slot_free) begin
      if (grant) begin
        ORAM_VLD <= 1'b1;
        ORAM_LST <= final_beat;
        ORAM_ADD <= {win_idx, win_add};
        ORAM_DAT <= win_dat;
      end else begin
        ORAM_VLD <= 1'b0;
        ORAM_LST <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eeg_pea_out_arb.sv
// Directed self-checking bench for eeg_pea_out_arb.
module tb_eeg_pea_out_arb;

  localparam int PE_NUM = 16;
  localparam int DW     = 8;
  localparam int AW     = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_start;
  logic                 is_idle, done;
  logic [PE_NUM-1:0]    pe_vld, pe_lst, pe_rdy;
  logic [PE_NUM*DW-1:0] pe_dat;
  logic [PE_NUM*AW-1:0] pe_add;
  logic                 oram_vld, oram_rdy, oram_lst;
  logic [11:0]          oram_add;
  logic [DW-1:0]        oram_dat;

  int compare_count  = 0;
  int mismatch_count = 0;
  int cnt[PE_NUM];
  int order[15] = '{0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};

  eeg_pea_out_arb dut (
    .clk(clk), .rst_n(rst_n), .CFG_START(cfg_start), .IS_IDLE(is_idle), .DONE(done),
    .PE_OUT_VLD(pe_vld), .PE_OUT_LST(pe_lst), .PE_OUT_RDY(pe_rdy),
    .PE_OUT_DAT(pe_dat), .PE_OUT_ADD(pe_add),
    .ORAM_VLD(oram_vld), .ORAM_RDY(oram_rdy), .ORAM_LST(oram_lst),
    .ORAM_ADD(oram_add), .ORAM_DAT(oram_dat)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one PE's output stream
  task automatic applyStimulus(input int idx, input logic vld, input logic lst,
                               input logic [DW-1:0] dat, input logic [AW-1:0] add);
    pe_vld[idx]          = vld;
    pe_lst[idx]          = lst;
    pe_dat[idx*DW +: DW] = dat;
    pe_add[idx*AW +: AW] = add;
  endtask

  function automatic logic [15:0] one_hot(input int i);
    return 16'(1) << i;
  endfunction

  // Pulse CFG_START from IDLE; RUN begins after the following edge
  task automatic startRun();
    @(negedge clk);
    cfg_start = 1'b1;
    #1;
    checkOutput("idle_rdy", 32'(pe_rdy), 32'h0);
    checkOutput("idle_flag", 32'(is_idle), 32'h1);
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  // After the final beat is in the slot: DONE one cycle after acceptance
  task automatic checkDrain(input string tag);
    @(negedge clk);
    for (int i = 0; i < PE_NUM; i++) applyStimulus(i, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    checkOutput({tag, "_drain_rdy"}, 32'(pe_rdy), 32'h0);
    checkOutput({tag, "_drain_done0"}, 32'(done), 32'h0);
    checkOutput({tag, "_drain_busy"}, 32'(is_idle), 32'h0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done"}, 32'(done), 32'h1);
    checkOutput({tag, "_idle"}, 32'(is_idle), 32'h1);
    checkOutput({tag, "_vld_off"}, 32'(oram_vld), 32'h0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'h0);
    checkOutput({tag, "_idle_next"}, 32'(is_idle), 32'h1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    oram_rdy  = 1'b1;
    pe_vld    = '0;
    pe_lst    = '0;
    pe_dat    = '0;
    pe_add    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_idle", 32'(is_idle), 32'h1);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_rdy", 32'(pe_rdy), 32'h0);
    checkOutput("rst_vld", 32'(oram_vld), 32'h0);
    checkOutput("rst_lst", 32'(oram_lst), 32'h0);
    checkOutput("rst_add", 32'(oram_add), 32'h0);
    checkOutput("rst_dat", 32'(oram_dat), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // All PEs always valid: grants rotate 0..15 from ptr=0
    for (int i = 0; i < PE_NUM; i++) applyStimulus(i, 1'b1, 1'b0, 8'(8'h30 + i), 8'(8'h40 + i));
    startRun();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      checkOutput("rr_rdy", 32'(pe_rdy), 32'(one_hot(k % 16)));
      if (k == 0) checkOutput("rr_latency", 32'(oram_vld), 32'h0);
      @(posedge clk);
      #1;
      checkOutput("rr_vld", 32'(oram_vld), 32'h1);
      checkOutput("rr_add", 32'(oram_add), 32'(((k % 16) << 8) | (8'h40 + (k % 16))));
      checkOutput("rr_dat", 32'(oram_dat), 32'(8'h30 + (k % 16)));
    end

    // Backpressure: slot holds PE 3's beat, nobody granted
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      oram_rdy = 1'b0;
      #1;
      checkOutput("bp_rdy", 32'(pe_rdy), 32'h0);
      @(posedge clk);
      #1;
      checkOutput("bp_vld", 32'(oram_vld), 32'h1);
      checkOutput("bp_add", 32'(oram_add), 32'h343);
      checkOutput("bp_dat", 32'(oram_dat), 32'h33);
    end
    @(negedge clk);
    oram_rdy = 1'b1;
    #1;
    checkOutput("bp_release_rdy", 32'(pe_rdy), 32'(one_hot(4)));
    @(posedge clk);
    #1;
    checkOutput("bp_release_add", 32'(oram_add), 32'h444);

    // Asynchronous reset mid-run drops the in-flight beat
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_vld", 32'(oram_vld), 32'h0);
    checkOutput("mid_rst_rdy", 32'(pe_rdy), 32'h0);
    checkOutput("mid_rst_idle", 32'(is_idle), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Two beats per PE, PE 3 keeps VLD after its last, CFG_START mid-run
    for (int i = 0; i < PE_NUM; i++) begin
      cnt[i] = 0;
      applyStimulus(i, 1'b1, 1'b0, 8'(i * 16), 8'h00);
    end
    startRun();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      for (int i = 0; i < PE_NUM; i++)
        applyStimulus(i, (cnt[i] < 2) || (i == 3), cnt[i] >= 1,
                      8'(i * 16 + cnt[i]), 8'(cnt[i]));
      cfg_start = (k == 24);
      #1;
      checkOutput("two_rdy", 32'(pe_rdy), 32'(one_hot(k % 16)));
      @(posedge clk);
      #1;
      checkOutput("two_add", 32'(oram_add), 32'(((k % 16) << 8) | (k / 16)));
      checkOutput("two_dat", 32'(oram_dat), 32'((k % 16) * 16 + (k / 16)));
      checkOutput("two_lst", 32'(oram_lst), 32'(k == 31));
      if (k == 24) checkOutput("cfg_ignored", 32'(is_idle), 32'h0);
      cnt[k % 16]++;
    end
    cfg_start = 1'b0;
    checkDrain("two");

    // Only PE 5 streams; others pre-marked by one last beat each
    for (int i = 0; i < PE_NUM; i++)
      applyStimulus(i, i != 5, i != 5, 8'(8'hE0 + i), 8'h00);
    startRun();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      #1;
      checkOutput("pre_rdy", 32'(pe_rdy), 32'(one_hot(order[k])));
      @(posedge clk);
      #1;
      checkOutput("pre_add", 32'(oram_add), 32'(order[k] << 8));
      checkOutput("pre_lst", 32'(oram_lst), 32'h0);
    end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      applyStimulus(5, 1'b1, b == 2, 8'(8'hA0 + b), 8'(8'h10 + b));
      #1;
      checkOutput("pe5_rdy", 32'(pe_rdy), 32'(one_hot(5)));
      @(posedge clk);
      #1;
      checkOutput("pe5_vld", 32'(oram_vld), 32'h1);
      checkOutput("pe5_add", 32'(oram_add), 32'(12'h510 + b));
      checkOutput("pe5_dat", 32'(oram_dat), 32'(8'hA0 + b));
      checkOutput("pe5_lst", 32'(oram_lst), 32'(b == 2));
    end
    checkDrain("pe5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
